// File: rtl/debug_run_controller_if.sv
// Debug-link port bundle for debug_run_controller: UART rx/tx bytes, pipeline halt, IF-stage controls.
// master is the controller side; slave is the UART / IF-stage side.
interface debug_run_controller_if #(
    parameter int SIZE_REG_MEM = 32,
    parameter int SIZE_ADDR    = 6
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_valid;
    logic                    i_flag_halt;
    logic                    i_tx_ready;
    logic [7:0]              o_tx_data;
    logic                    o_tx_valid;
    logic [SIZE_REG_MEM-1:0] o_instruction_debug;
    logic                    o_flag_instruction_debug;
    logic [SIZE_ADDR-1:0]    o_load_addr;
    logic                    o_flag_start_pc;
    logic                    o_enable;

    modport master (
        input  i_rx_data, i_rx_valid, i_flag_halt, i_tx_ready,
        output o_tx_data, o_tx_valid, o_instruction_debug, o_flag_instruction_debug,
               o_load_addr, o_flag_start_pc, o_enable
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_flag_halt, i_tx_ready,
        input  o_tx_data, o_tx_valid, o_instruction_debug, o_flag_instruction_debug,
               o_load_addr, o_flag_start_pc, o_enable
    );
endinterface

// File: rtl/debug_run_controller.sv
// Debug-link sequencer: loads program words from UART bytes, then runs/steps the PC; DEBUG_STEP_EN adds 'S'.
// Latency: write strobe 1 cycle after last byte of a word, ACK 1 cycle after final write, run pulse 1 cycle after 'C'.
// Backpressure: response held stable on o_tx_valid until i_tx_ready; rx bytes outside IDLE/GET_* are dropped.
module debug_run_controller #(
    parameter int SIZE_REG_MEM = 32,
    parameter int MEM_DEPTH    = 64,
    parameter int SIZE_ADDR    = 6
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    debug_run_controller_if.master dbg
);
    localparam int         BYTES_PER_WORD = SIZE_REG_MEM / 8;
    localparam logic [7:0] LAST_BYTE      = 8'(BYTES_PER_WORD - 1);
    localparam logic [7:0] DEPTH_MAX      = 8'(MEM_DEPTH);
    localparam logic [7:0] CMD_LOAD       = 8'h4C;
    localparam logic [7:0] CMD_RUN        = 8'h43;
`ifdef DEBUG_STEP_EN
    localparam logic [7:0] CMD_STEP       = 8'h53;
`endif
    localparam logic [7:0] RSP_ACK        = 8'h06;
    localparam logic [7:0] RSP_NAK        = 8'h15;
    localparam logic [7:0] RSP_HALT       = 8'h48;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_BYTE,
        WRITE,
        RUN,
`ifdef DEBUG_STEP_EN
        STEP,
`endif
        SEND
    } state_t;

    state_t                  state, state_nxt;
    logic [SIZE_REG_MEM-1:0] word, word_nxt;
    logic [7:0]              byte_cnt, byte_cnt_nxt;
    logic [7:0]              count, count_nxt;
    logic [7:0]              word_cnt, word_cnt_nxt;
    logic [7:0]              tx_byte, tx_byte_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            word     <= '0;
            byte_cnt <= '0;
            count    <= '0;
            word_cnt <= '0;
            tx_byte  <= '0;
        end else begin
            state    <= state_nxt;
            word     <= word_nxt;
            byte_cnt <= byte_cnt_nxt;
            count    <= count_nxt;
            word_cnt <= word_cnt_nxt;
            tx_byte  <= tx_byte_nxt;
        end
    end

    always_comb begin
        state_nxt                    = state;
        word_nxt                     = word;
        byte_cnt_nxt                 = byte_cnt;
        count_nxt                    = count;
        word_cnt_nxt                 = word_cnt;
        tx_byte_nxt                  = tx_byte;
        dbg.o_tx_data                = '0;
        dbg.o_tx_valid               = 1'b0;
        dbg.o_instruction_debug      = '0;
        dbg.o_flag_instruction_debug = 1'b0;
        dbg.o_load_addr              = '0;
        dbg.o_flag_start_pc          = 1'b0;
        dbg.o_enable                 = 1'b0;

        case (state)
            IDLE: begin
                if (dbg.i_rx_valid) begin
                    case (dbg.i_rx_data)
                        CMD_LOAD: state_nxt = GET_COUNT;
                        CMD_RUN:  state_nxt = RUN;
`ifdef DEBUG_STEP_EN
                        CMD_STEP: state_nxt = STEP;
`endif
                        default: begin
                            tx_byte_nxt = RSP_NAK;
                            state_nxt   = SEND;
                        end
                    endcase
                end
            end
            GET_COUNT: begin
                if (dbg.i_rx_valid) begin
                    if (dbg.i_rx_data == 8'd0 || dbg.i_rx_data > DEPTH_MAX) begin
                        tx_byte_nxt = RSP_NAK;
                        state_nxt   = SEND;
                    end else begin
                        count_nxt    = dbg.i_rx_data;
                        word_cnt_nxt = '0;
                        byte_cnt_nxt = '0;
                        state_nxt    = GET_BYTE;
                    end
                end
            end
            GET_BYTE: begin
                // MSB-first: each new byte pushes the earlier ones toward the top
                if (dbg.i_rx_valid) begin
                    word_nxt = (word << 8) | SIZE_REG_MEM'(dbg.i_rx_data);
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_nxt = '0;
                        state_nxt    = WRITE;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 8'd1;
                    end
                end
            end
            WRITE: begin
                dbg.o_flag_instruction_debug = 1'b1;
                dbg.o_instruction_debug      = word;
                dbg.o_load_addr              = SIZE_ADDR'(word_cnt);
                word_cnt_nxt                 = word_cnt + 8'd1;
                if (word_cnt + 8'd1 == count) begin
                    tx_byte_nxt = RSP_ACK;
                    state_nxt   = SEND;
                end else begin
                    state_nxt   = GET_BYTE;
                end
            end
            RUN: begin
                dbg.o_flag_start_pc = 1'b1;
                dbg.o_enable        = 1'b1;
                if (dbg.i_flag_halt) begin
                    tx_byte_nxt = RSP_HALT;
                    state_nxt   = SEND;
                end
            end
`ifdef DEBUG_STEP_EN
            STEP: begin
                dbg.o_flag_start_pc = 1'b1;
                dbg.o_enable        = 1'b1;
                tx_byte_nxt         = dbg.i_flag_halt ? RSP_HALT : RSP_ACK;
                state_nxt           = SEND;
            end
`endif
            SEND: begin
                // tx_byte is only loaded on entry here, so the byte stays put while stalled
                dbg.o_tx_valid = 1'b1;
                dbg.o_tx_data  = tx_byte;
                if (dbg.i_tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_debug_run_controller.sv
// Bench for debug_run_controller: command-vector table plus hand sequences, scoreboarded writes and responses.
module tb_debug_run_controller;
    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;
    localparam logic [7:0] HALT = 8'h48;

    logic clk = 1'b0;
    logic rst = 1'b1;

    debug_run_controller_if #(.SIZE_REG_MEM(W), .SIZE_ADDR(AW)) dbg();

    debug_run_controller #(.SIZE_REG_MEM(W), .MEM_DEPTH(DEPTH), .SIZE_ADDR(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .dbg     (dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         two;
        logic [7:0] rsp;
        string      name;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         strobe_cnt = 0;
    int         run_cnt = 0;
    int         en_cnt = 0;
    wr_t        wr_q[$];
    logic [7:0] rsp_q[$];
    logic [W-1:0] ld_words[DEPTH];
    logic       prev_vld = 1'b0;
    logic       prev_acc = 1'b0;
    logic [7:0] prev_dat = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, inputs change just after the rising edge
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] r;
        if (dbg.o_flag_instruction_debug) begin
            strobe_cnt++;
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: addr=0x%0h data=0x%0h, none expected",
                         dbg.o_load_addr, dbg.o_instruction_debug);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(dbg.o_load_addr), 64'(e.addr));
                check("wr_data", 64'(dbg.o_instruction_debug), 64'(e.data));
            end
        end
        if (dbg.o_tx_valid && dbg.i_tx_ready) begin
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: tx=0x%0h, none expected", dbg.o_tx_data);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_byte", 64'(dbg.o_tx_data), 64'(r));
            end
        end
        if (!rst && prev_vld && !prev_acc) begin
            check("tx_hold_vld", 64'(dbg.o_tx_valid), 64'd1);
            check("tx_hold_dat", 64'(dbg.o_tx_data), 64'(prev_dat));
        end
        if (dbg.o_flag_start_pc) run_cnt++;
        if (dbg.o_enable) en_cnt++;
        prev_vld = dbg.o_tx_valid && !rst;
        prev_acc = dbg.o_tx_valid && dbg.i_tx_ready;
        prev_dat = dbg.o_tx_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        dbg.i_rx_data  = b;
        dbg.i_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        dbg.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W/8 - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    // Loads ld_words[0..n-1]; one idle cycle per word covers the WRITE cycle, where rx is ignored
    task automatic load_words(input int n);
        rsp_q.push_back(ACK);
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            wr_q.push_back('{AW'(k), ld_words[k]});
            send_word(ld_words[k]);
            tick(1);
        end
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while ((wr_q.size() != 0 || rsp_q.size() != 0) && cyc < 400) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (cyc >= 400) begin
            failures++;
            $display("FAIL %s_timeout: %0d writes and %0d responses still pending after 400 cycles",
                     name, wr_q.size(), rsp_q.size());
            wr_q.delete();
            rsp_q.delete();
        end
        tick(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_data"}, 64'(dbg.o_tx_data), 64'd0);
        check({tag, "_tx_valid"}, 64'(dbg.o_tx_valid), 64'd0);
        check({tag, "_instr"}, 64'(dbg.o_instruction_debug), 64'd0);
        check({tag, "_strobe"}, 64'(dbg.o_flag_instruction_debug), 64'd0);
        check({tag, "_addr"}, 64'(dbg.o_load_addr), 64'd0);
        check({tag, "_start_pc"}, 64'(dbg.o_flag_start_pc), 64'd0);
        check({tag, "_enable"}, 64'(dbg.o_enable), 64'd0);
    endtask

    vec_t       vecs[6];
    logic [7:0] bp_bytes[7];
    int         s0;
    int         cyc;

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, NAK, "unk_00"};
        vecs[1] = '{8'hFF, 8'h00, 1'b0, NAK, "unk_ff"};
        vecs[2] = '{8'h06, 8'h00, 1'b0, NAK, "unk_06"};
        vecs[3] = '{8'h4C, 8'h00, 1'b1, NAK, "count_zero"};
        vecs[4] = '{8'h4C, 8'(DEPTH + 1), 1'b1, NAK, "count_over"};
        vecs[5] = '{8'h4C, 8'hFF, 1'b1, NAK, "count_255"};
        bp_bytes = '{8'h4C, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h43};

        dbg.i_rx_data   = 8'h00;
        dbg.i_rx_valid  = 1'b0;
        dbg.i_flag_halt = 1'b0;
        dbg.i_tx_ready  = 1'b1;
        rst = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(1);

        // Basic two-word load
        ld_words[0] = 32'h20010005;
        ld_words[1] = 32'hFFFFFFFF;
        load_words(2);
        wait_done("load2");

        // Command/count rejection vectors
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            rsp_q.push_back(vecs[i].rsp);
            send_byte(vecs[i].b0);
            if (vecs[i].two) send_byte(vecs[i].b1);
            wait_done(vecs[i].name);
        end
        check("nak_no_strobe", 64'(strobe_cnt), 64'(s0));

        // Run, halt raised during the tenth run cycle
        run_cnt = 0;
        en_cnt  = 0;
        rsp_q.push_back(HALT);
        send_byte(8'h43);
        tick(9);
        dbg.i_flag_halt = 1'b1;
        tick(1);
        dbg.i_flag_halt = 1'b0;
        wait_done("run");
        check("run_start_cycles", 64'(run_cnt), 64'd10);
        check("run_enable_cycles", 64'(en_cnt), 64'd10);

        // Halt already high when RUN is entered
        run_cnt = 0;
        dbg.i_flag_halt = 1'b1;
        rsp_q.push_back(HALT);
        send_byte(8'h43);
        tick(1);
        dbg.i_flag_halt = 1'b0;
        wait_done("run_prehalt");
        check("run_prehalt_cycles", 64'(run_cnt), 64'd1);

`ifdef DEBUG_STEP_EN
        for (int k = 0; k < 3; k++) begin
            en_cnt = 0;
            rsp_q.push_back(ACK);
            send_byte(8'h53);
            wait_done("step");
            check("step_pulse", 64'(en_cnt), 64'd1);
        end
        en_cnt = 0;
        dbg.i_flag_halt = 1'b1;
        rsp_q.push_back(HALT);
        send_byte(8'h53);
        tick(1);
        dbg.i_flag_halt = 1'b0;
        wait_done("step_halt");
        check("step_halt_pulse", 64'(en_cnt), 64'd1);
`else
        en_cnt = 0;
        rsp_q.push_back(NAK);
        send_byte(8'h53);
        wait_done("step_off");
        check("step_off_enable", 64'(en_cnt), 64'd0);
`endif

        // Backpressure on the ACK with rx traffic that must be dropped
        dbg.i_tx_ready = 1'b0;
        ld_words[0] = 32'hDEADBEEF;
        load_words(1);
        cyc = 0;
        while (!dbg.o_tx_valid && cyc < 10) begin
            tick(1);
            cyc++;
        end
        check("bp_tx_up", 64'(dbg.o_tx_valid), 64'd1);
        s0 = strobe_cnt;
        en_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", 64'(dbg.o_tx_valid), 64'd1);
            check("bp_data", 64'(dbg.o_tx_data), 64'(ACK));
            if (c >= 2 && c < 9) send_byte(bp_bytes[c-2]);
            else tick(1);
        end
        check("bp_no_strobe", 64'(strobe_cnt), 64'(s0));
        check("bp_no_enable", 64'(en_cnt), 64'd0);
        dbg.i_tx_ready = 1'b1;
        wait_done("bp_release");

        // Reset after two of four bytes of a word
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        tick(1);
        check_outputs_zero("midload");
        rst = 1'b0;
        tick(5);
        check("midload_no_ack", 64'(dbg.o_tx_valid), 64'd0);
        ld_words[0] = 32'h12345678;
        load_words(1);
        wait_done("reload");

        // Full-depth load reaches the last address
        for (int k = 0; k < DEPTH; k++) ld_words[k] = $urandom;
        load_words(DEPTH);
        wait_done("load_full");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
